// File: rtl/uart_prog_loader_pkg.sv
// Shared constants, state encodings and helpers for the UART program loader.
package uart_prog_loader_pkg;

  localparam logic [7:0] LDR_HDR      = 8'hA5;
  localparam logic [7:0] LDR_TGT_IMEM = 8'h00;
  localparam logic [7:0] LDR_TGT_DMEM = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_HDR = 4'd1,
    ST_TARGET   = 4'd2,
    ST_CNT_HI   = 4'd3,
    ST_CNT_LO   = 4'd4,
    ST_DATA     = 4'd5,
    ST_CHK      = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // A divisor of zero would stall the oversampler, so clamp to one.
  function automatic int unsigned rx_divisor(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * 16);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampler, LSB-first shifter.
module uart_rx_core
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 23000000,
  parameter int unsigned BAUD        = 128000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned DIV   = rx_divisor(CLK_FREQ_HZ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

  logic [1:0]       sync_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             tick;

  assign rx_s = sync_q[1];
  assign tick = (div_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != RX_IDLE) begin
      div_d = tick ? DIV_RELOAD : div_q - DIV_W'(1);
    end

    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          div_d   = DIV_RELOAD;
          os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_s) begin
              state_d = RX_IDLE;
            end else begin
              state_d = RX_DATA;
              os_d    = '0;
              bit_d   = '0;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            os_d    = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            state_d = RX_IDLE;
            valid_d = rx_s;
            ferr_d  = !rx_s;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser that loads a serial image into instruction or data memory
// while holding the CPU in reset, releasing it only on a verified checksum.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 23000000,
  parameter int unsigned BAUD           = 128000,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 2300000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  start_load,
  output logic                  cpu_hold,
  output logic                  imem_we,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_core #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ldr_state_e            state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [7:0]            xor_q, xor_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  iwe_q, iwe_d;
  logic                  dwe_q, dwe_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  logic        timed;
  logic        tmo;
  logic [15:0] n_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      iwe_q   <= 1'b0;
      dwe_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      iwe_q   <= iwe_d;
      dwe_q   <= dwe_d;
      tmr_q   <= tmr_d;
    end
  end

  assign timed = (state_q == ST_TARGET) || (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                 (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign tmo   = timed && !byte_valid && (tmr_q == TMR_W'(1));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    iwe_d   = 1'b0;
    dwe_d   = 1'b0;
    tmr_d   = tmr_q;
    n_full  = {cnt_q[15:8], byte_data};

    // Address advances in the cycle after each write strobe.
    if (iwe_q || dwe_q) addr_d = addr_q + ADDR_WIDTH'(1);

    if (timed) begin
      if (byte_valid)          tmr_d = TMR_LOAD;
      else if (tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_load) begin
          state_d = ST_WAIT_HDR;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          xor_d   = '0;
          bidx_d  = '0;
        end
      end
      ST_WAIT_HDR: begin
        if (byte_valid && byte_data == LDR_HDR) begin
          state_d = ST_TARGET;
          tmr_d   = TMR_LOAD;
        end
      end
      ST_TARGET: begin
        if (byte_valid) begin
          if (byte_data == LDR_TGT_IMEM) begin
            tgt_d   = 1'b0;
            state_d = ST_CNT_HI;
          end else if (byte_data == LDR_TGT_DMEM) begin
            tgt_d   = 1'b1;
            state_d = ST_CNT_HI;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_CNT_HI: begin
        if (byte_valid) begin
          cnt_d   = {byte_data, cnt_q[7:0]};
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (byte_valid) begin
          cnt_d  = n_full;
          bidx_d = '0;
          if (n_full == 16'd0)                        state_d = ST_CHK;
          else if ({17'd0, n_full} > MAX_WORDS)       state_d = ST_ERR;
          else                                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          data_d = {data_q[23:0], byte_data};
          xor_d  = xor_q ^ byte_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            iwe_d = !tgt_q;
            dwe_d = tgt_q;
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (byte_valid) begin
          state_d = (byte_data == xor_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_ERR;
    endcase

    if (timed && (frame_err || tmo)) state_d = ST_ERR;

    // Flags settle on the transition so they are held while parked in DONE/ERR.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      hold_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (state_d == ST_ERR && state_q != ST_ERR) begin
      busy_d = 1'b0;
      err_d  = 1'b1;
    end
  end

  assign cpu_hold  = hold_q;
  assign imem_we   = iwe_q;
  assign dmem_we   = dwe_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboarded bench for uart_prog_loader: 16 clocks per serial bit.
module tb_uart_prog_loader;

  localparam int unsigned CLK_FREQ_HZ    = 1600000;
  localparam int unsigned BAUD           = 100000;
  localparam int unsigned ADDR_WIDTH     = 14;
  localparam int unsigned TIMEOUT_CYCLES = 2000;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  uart_rx;
  logic                  start_load;
  logic                  cpu_hold;
  logic                  imem_we;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  load_done;
  logic                  load_err;

  uart_prog_loader #(
    .CLK_FREQ_HZ    (CLK_FREQ_HZ),
    .BAUD           (BAUD),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .start_load (start_load),
    .cpu_hold   (cpu_hold),
    .imem_we    (imem_we),
    .dmem_we    (dmem_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic                  dmem;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          errors = 0;
  int          checks = 0;

  // Advance one clock and score any write strobe against the expected queue.
  task automatic cyc();
    wr_t e;
    @(posedge clock);
    #1;
    if (imem_we || dmem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got imem_we=%0b dmem_we=%0b addr=%0d data=%h, expected no write", imem_we, dmem_we, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({dmem_we, imem_we, wr_addr, wr_data} !== {e.dmem, !e.dmem, e.addr, e.data}) begin
          errors++;
          $display("FAIL write_match: got imem_we=%0b dmem_we=%0b addr=%0d data=%h, expected dmem=%0b addr=%0d data=%h", imem_we, dmem_we, wr_addr, wr_data, e.dmem, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (16) cyc();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    uart_rx = 1'b1;
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (4) cyc();
    uart_rx = 1'b1;
    repeat (40) cyc();
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
  endtask

  task automatic push_word(input logic dmem, input int idx, input logic [31:0] w);
    wr_t e;
    e.dmem = dmem;
    e.addr = ADDR_WIDTH'(idx);
    e.data = w;
    exp_q.push_back(e);
  endtask

  // Sends header, target, count, the words queue and a checksum (computed or forced).
  task automatic send_frame(input logic [7:0] tgt, input logic force_chk, input logic [7:0] chk_val);
    logic [15:0] n;
    logic [7:0]  chk;
    logic [31:0] w;
    n   = 16'(words.size());
    chk = 8'h00;
    send_byte(8'hA5);
    send_byte(tgt);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      push_word(tgt[0], i, w);
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8]);
        chk = chk ^ w[8*b +: 8];
      end
    end
    send_byte(force_chk ? chk_val : chk);
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({cpu_hold, imem_we, dmem_we, busy, load_done, load_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got hold,iwe,dwe,busy,done,err=%b, expected 000000", {cpu_hold, imem_we, dmem_we, busy, load_done, load_err});
    end
    checks++;
    if (wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d, expected 0", wr_addr);
    end
    checks++;
    if (wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 00000000", wr_data);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_good_imem();
    pulse_start();
    checks++;
    if ({cpu_hold, busy, load_done, load_err} !== 4'b1100) begin
      errors++;
      $display("FAIL start_flags: got hold,busy,done,err=%b, expected 1100", {cpu_hold, busy, load_done, load_err});
    end
    words = '{32'hDEADBEEF, 32'h01234567};
    send_frame(8'h00, 1'b0, 8'h00);
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b1000) begin
      errors++;
      $display("FAIL good_imem_end: got done,hold,busy,err=%b, expected 1000", {load_done, cpu_hold, busy, load_err});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_imem_writes: %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_chk();
    pulse_start();
    words = '{32'hDEADBEEF, 32'h01234567};
    send_frame(8'h00, 1'b1, 8'h00);
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b0101) begin
      errors++;
      $display("FAIL bad_chk_end: got done,hold,busy,err=%b, expected 0101", {load_done, cpu_hold, busy, load_err});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_chk_writes: %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_noise_dmem();
    pulse_start();
    send_byte(8'h3C);
    send_byte(8'hFF);
    checks++;
    if ({busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL noise_discard: got busy,err=%b, expected 10", {busy, load_err});
    end
    words = '{32'h0000002A};
    send_frame(8'h01, 1'b0, 8'h00);
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL noise_dmem_end: got done,hold,busy,err=%b missing=%0d, expected 1000 missing=0", {load_done, cpu_hold, busy, load_err}, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int waited;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    repeat (1500) cyc();
    checks++;
    if ({busy, load_err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early: got busy,err=%b, expected 10", {busy, load_err});
    end
    waited = 0;
    while (load_err !== 1'b1 && waited < 1000) begin
      cyc();
      waited++;
    end
    checks++;
    if ({load_err, cpu_hold, busy, load_done} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_err: got err,hold,busy,done=%b after %0d cycles, expected 1100", {load_err, cpu_hold, busy, load_done}, waited);
    end
  endtask

  task automatic test_glitch_framing();
    pulse_start();
    glitch();
    send_byte(8'hA5);
    send_byte(8'h01);
    glitch();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    push_word(1'b1, 0, 32'h0000002A);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h2A);
    send_byte(8'h2A);
    repeat (4) cyc();
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_ignored: got done,hold,busy,err=%b missing=%0d, expected 1000 missing=0", {load_done, cpu_hold, busy, load_err}, exp_q.size());
    end
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00, 1'b0);
    repeat (20) cyc();
    checks++;
    if ({load_err, cpu_hold, busy, load_done} !== 4'b1100) begin
      errors++;
      $display("FAIL framing_err: got err,hold,busy,done=%b, expected 1100", {load_err, cpu_hold, busy, load_done});
    end
  endtask

  task automatic test_boundaries();
    int waited;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (4) cyc();
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_words: got done,hold,busy,err=%b, expected 1000", {load_done, cpu_hold, busy, load_err});
    end
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h01);
    repeat (4) cyc();
    checks++;
    if ({load_err, cpu_hold, busy} !== 3'b110) begin
      errors++;
      $display("FAIL count_too_big: got err,hold,busy=%b, expected 110", {load_err, cpu_hold, busy});
    end
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    repeat (4) cyc();
    checks++;
    if ({load_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL count_max_ok: got err,busy=%b, expected 01", {load_err, busy});
    end
    waited = 0;
    while (load_err !== 1'b1 && waited < 2500) begin
      cyc();
      waited++;
    end
    checks++;
    if (load_err !== 1'b1 || waited < 1900) begin
      errors++;
      $display("FAIL data_timeout: got err=%b after %0d cycles, expected 1 after 1900..2500", load_err, waited);
    end
  endtask

  task automatic test_reset_mid_data();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    reset = 1'b1;
    cyc();
    checks++;
    if ({cpu_hold, imem_we, dmem_we, busy, load_done, load_err} !== 6'b0 || wr_addr !== '0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b addr=%0d data=%h, expected 000000 0 00000000", {cpu_hold, imem_we, dmem_we, busy, load_done, load_err}, wr_addr, wr_data);
    end
    reset = 1'b0;
    cyc();
    pulse_start();
    words = '{32'hCAFEF00D, 32'h12345678};
    send_frame(8'h00, 1'b0, 8'h00);
    checks++;
    if ({load_done, cpu_hold, busy, load_err} !== 4'b1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_load: got done,hold,busy,err=%b missing=%0d, expected 1000 missing=0", {load_done, cpu_hold, busy, load_err}, exp_q.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    uart_rx    = 1'b1;
    start_load = 1'b0;
    test_reset();
    test_good_imem();
    test_bad_chk();
    test_noise_dmem();
    test_timeout();
    test_glitch_framing();
    test_boundaries();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
